// File: rtl/warn_arbiter.sv
// warn_arbiter: round-robin arbiter sharing one timed alarm output among NUM_CH warning channels.
// Escalation counter is compiled in only when WARN_ESCALATE_EN is defined.
module warn_arbiter #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned ALARM_CYCLES    = 1000,
    parameter int unsigned COOLDOWN_CYCLES = 200,
    parameter int unsigned ESC_THRESH      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         warn_in,
    input  logic                      ack,
    output logic                      alarm,
    output logic [$clog2(NUM_CH)-1:0] alarm_ch,
    output logic [NUM_CH-1:0]         pend,
    output logic                      escalate
);
    localparam int unsigned CHW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ALARM,
        S_COOL
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic [NUM_CH-1:0] warn_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pick_mask;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [CHW-1:0]    ptr_q, ptr_d;
    logic [CHW-1:0]    pick;
    logic              alarm_q;
    logic              found;
    int unsigned       rr_idx;

    // First set pend bit at or above ptr_q, wrapping modulo NUM_CH.
    always_comb begin : rr_pick
        found  = 1'b0;
        pick   = '0;
        rr_idx = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rr_idx = ptr_q + i;
            if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
            if (!found && pend_q[CHW'(rr_idx)]) begin
                found = 1'b1;
                pick  = CHW'(rr_idx);
            end
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        timer_d   = timer_q;
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        pick_mask = '0;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) state_d = S_GRANT;
            end
            S_GRANT: begin
                ch_d            = pick;
                pick_mask[pick] = 1'b1;
                ptr_d           = (pick == CHW'(NUM_CH - 1)) ? '0 : pick + CHW'(1);
                timer_d         = 16'(ALARM_CYCLES - 1);
                state_d         = S_ALARM;
            end
            S_ALARM: begin
                if (ack || timer_q == '0) begin
                    timer_d = 16'(COOLDOWN_CYCLES - 1);
                    state_d = S_COOL;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_COOL: begin
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh edge wins over the grant clearing the same bit.
        pend_d = (pend_q & ~pick_mask) | (warn_in & ~warn_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            warn_q  <= '0;
            pend_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            warn_q  <= warn_in;
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            alarm_q <= (state_d == S_ALARM);
        end
    end

    assign alarm    = alarm_q;
    assign alarm_ch = ch_q;
    assign pend     = pend_q;

`ifdef WARN_ESCALATE_EN
    logic [3:0] esc_cnt_q, esc_cnt_d;

    // Counts consecutive timed-out alarms; saturates rather than wrapping.
    always_comb begin : esc_next
        esc_cnt_d = esc_cnt_q;
        if (state_q == S_ALARM) begin
            if (ack)
                esc_cnt_d = '0;
            else if (timer_q == '0 && esc_cnt_q != 4'hF)
                esc_cnt_d = esc_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) esc_cnt_q <= '0;
        else        esc_cnt_q <= esc_cnt_d;
    end

    assign escalate = (esc_cnt_q >= 4'(ESC_THRESH));
`else
    // Constant 0; ESC_THRESH stays referenced so both builds share one parameter list.
    assign escalate = 1'b0 & (ESC_THRESH == 0);
`endif

endmodule

// File: tb/tb_warn_arbiter.sv
// Self-checking bench for warn_arbiter: directed table, corner sequences, and random stimulus
// compared every cycle against a timestamp-based reference model.
module tb_warn_arbiter;
    localparam int N = 4;
    localparam int A = 10;
    localparam int C = 5;
    localparam int E = 3;
`ifdef WARN_ESCALATE_EN
    localparam bit ESC_ON = 1'b1;
`else
    localparam bit ESC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] warn_in;
    logic       ack;
    logic       alarm;
    logic [1:0] alarm_ch;
    logic [3:0] pend;
    logic       escalate;

    always #5 clk = ~clk;

    warn_arbiter #(
        .NUM_CH(N),
        .ALARM_CYCLES(A),
        .COOLDOWN_CYCLES(C),
        .ESC_THRESH(E)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .warn_in(warn_in),
        .ack(ack),
        .alarm(alarm),
        .alarm_ch(alarm_ch),
        .pend(pend),
        .escalate(escalate)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: service windows tracked as absolute edge numbers.
    int         k = 0;
    bit         busy = 1'b0;
    int         a_start = -100;
    int         a_stop  = -100;
    logic [3:0] m_pend = '0;
    logic [3:0] m_prev = '0;
    int         m_ptr = 0;
    int         m_ch  = 0;
    int         m_cnt = 0;
    bit         e_alarm;
    int         chq[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] w, input logic a);
        logic [3:0] rise;
        logic [3:0] clr;
        rise = w & ~m_prev;
        clr  = '0;
        if (!r) begin
            busy = 0; m_pend = '0; m_prev = '0; m_ptr = 0; m_ch = 0; m_cnt = 0;
            a_start = -100; a_stop = -100;
        end else begin
            if (!busy) begin
                if (m_pend != 0) begin
                    busy    = 1;
                    a_start = k + 1;
                    a_stop  = k + 1 + A;
                end
            end else if (k == a_start) begin
                for (int i = 0; i < N; i++) begin
                    int c = (m_ptr + i) % N;
                    if (m_pend[c] && clr == 0) begin
                        clr[c] = 1'b1;
                        m_ch   = c;
                    end
                end
                m_ptr = (m_ch + 1) % N;
            end else if (k <= a_stop) begin
                if (a) begin
                    m_cnt  = 0;
                    a_stop = k;
                end else if (k == a_stop) begin
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                end
            end else if (k == a_stop + C) begin
                busy = 0;
            end
            m_pend = (m_pend & ~clr) | rise;
            m_prev = w;
        end
        e_alarm = busy && (k >= a_start) && (k < a_stop);
        k++;
    endtask

    task automatic cyc(input logic r, input logic [3:0] w, input logic a);
        rst_n   = r;
        warn_in = w;
        ack     = a;
        @(posedge clk);
        model_step(r, w, a);
        #1;
        check("cyc_alarm", int'(alarm), int'(e_alarm));
        check("cyc_ch", int'(alarm_ch), m_ch);
        check("cyc_pend", int'(pend), int'(m_pend));
        check("cyc_esc", int'(escalate), (ESC_ON && m_cnt >= E) ? 1 : 0);
    endtask

    task automatic run(input int n, input logic [3:0] w, output int rises, output int lastch);
        logic pa;
        rises  = 0;
        lastch = -1;
        for (int i = 0; i < n; i++) begin
            pa = alarm;
            cyc(1'b1, w, 1'b0);
            if (alarm && !pa) begin
                rises++;
                lastch = int'(alarm_ch);
                chq.push_back(lastch);
            end
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] w;
        logic       a;
        logic       ea;
        logic [1:0] ech;
        logic [3:0] ep;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int r1, r2, lc, hi, got;
        logic an;
        int ex[3];
        ex = '{0, 1, 3};

        for (int i = 0; i < 18; i++) begin
            tbl[i].r   = 1'b1;
            tbl[i].w   = 4'b0100;
            tbl[i].a   = 1'b0;
            tbl[i].ea  = (i >= 2 && i < 12);
            tbl[i].ech = (i >= 2) ? 2'd2 : 2'd0;
            tbl[i].ep  = (i < 2) ? 4'b0100 : 4'b0000;
        end

        rst_n = 1'b0; warn_in = '0; ack = 1'b0;
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_ch", int'(alarm_ch), 0);
        check("rst_esc", int'(escalate), 0);

        // Single request on ch2: 10 alarm cycles then 5 cooldown cycles.
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].r, tbl[i].w, tbl[i].a);
            check("tbl_alarm", int'(alarm), int'(tbl[i].ea));
            check("tbl_ch", int'(alarm_ch), int'(tbl[i].ech));
            check("tbl_pend", int'(pend), int'(tbl[i].ep));
        end

        // Simultaneous requests on ch0, ch1, ch3 served in round-robin order.
        cyc(1'b0, 4'b0000, 1'b0);
        chq.delete();
        run(60, 4'b1011, r1, lc);
        check("rr_count", chq.size(), 3);
        for (int i = 0; i < 3; i++)
            check("rr_order", (i < chq.size()) ? chq[i] : -1, ex[i]);

        // Ack on the third alarm cycle shortens the alarm to 3 cycles.
        run(1, 4'b0000, r1, lc);
        hi = 0; an = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 4'b0100, an);
            an = 1'b0;
            if (alarm) begin
                hi++;
                if (hi == 3) an = 1'b1;
            end
        end
        check("ack_len", hi, 3);

        // Held level raises one request; drop/raise during alarm queues a second.
        run(5, 4'b0000, r1, lc);
        run(60, 4'b0010, r1, lc);
        check("held_once", r1, 1);
        run(3, 4'b0000, r1, lc);
        run(5, 4'b0010, r1, lc);
        check("held_first", r1, 1);
        check("alarm_at_drop", int'(alarm), 1);
        run(1, 4'b0000, r2, lc);
        run(60, 4'b0010, r2, lc);
        check("rearm_count", r2, 1);
        check("rearm_ch", lc, 1);

        // Reset mid-alarm clears everything, including a queued request.
        run(20, 4'b0000, r1, lc);
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            cyc(1'b1, 4'b0001, 1'b0);
            got = int'(alarm);
        end
        check("wait_alarm", got, 1);
        cyc(1'b1, 4'b0101, 1'b0);
        check("queued_pend", int'(pend), 4'b0100);
        cyc(1'b0, 4'b0000, 1'b0);
        check("midrst_alarm", int'(alarm), 0);
        check("midrst_pend", int'(pend), 0);
        check("midrst_ch", int'(alarm_ch), 0);
        check("midrst_esc", int'(escalate), 0);
        run(30, 4'b0000, r1, lc);
        check("midrst_noserve", r1, 0);

        // New edge arriving in the GRANT cycle keeps the pend bit set.
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        check("setprio_alarm", int'(alarm), 1);
        check("setprio_pend", int'(pend), 4'b0001);
        run(40, 4'b0000, r1, lc);
        check("setprio_serve", r1, 1);

        // Escalation after three timed-out alarms, cleared by ack.
        cyc(1'b0, 4'b0000, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 4'b0001, 1'b0);
            run(20, 4'b0000, r1, lc);
            if (j == 1) check("esc_after2", int'(escalate), 0);
        end
        check("esc_after3", int'(escalate), ESC_ON ? 1 : 0);
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            cyc(1'b1, 4'b0001, 1'b0);
            got = int'(alarm);
        end
        check("esc_wait4", got, 1);
        cyc(1'b1, 4'b0000, 1'b1);
        check("esc_ack_clr", int'(escalate), 0);
        check("esc_ack_alarm", int'(alarm), 0);
        run(20, 4'b0000, r1, lc);

        // Random traffic checked against the model every cycle.
        begin
            logic [3:0] w;
            logic       rr, aa;
            w = '0;
            for (int i = 0; i < 4000; i++) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 5) == 0) w[b] = ~w[b];
                aa = ($urandom_range(0, 7) == 0);
                rr = ($urandom_range(0, 399) != 0);
                cyc(rr, w, aa);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/warn_arbiter.md
WARN_ARBITER -- requirements
Module: warn_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of stack_warning channels sharing one alarm output (2..8).
REQ-002 SHALL have parameter ALARM_CYCLES, default 1000: alarm hold duration in clk cycles (1..65535).
REQ-003 SHALL have parameter COOLDOWN_CYCLES, default 200: dead time after each alarm in clk cycles (1..65535).
REQ-004 SHALL have parameter ESC_THRESH, default 3: consecutive unacknowledged alarms that trigger escalation (1..15).
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port warn_in, input, NUM_CH: level warning per channel, one stack_warning output per bit.
REQ-008 SHALL have port ack, input, 1: operator acknowledge, one-cycle pulse.
REQ-009 SHALL have port alarm, output reg, 1: shared alarm drive.
REQ-010 SHALL have port alarm_ch, output reg, $clog2(NUM_CH): index of the channel being alarmed.
REQ-011 SHALL have port pend, output reg, NUM_CH: latched pending requests.
REQ-012 SHALL have port escalate, output reg, 1: escalation flag.

Function
REQ-013 SHALL keep a registered copy of warn_in; a pending bit sets on a 0->1 edge of its warn_in bit only, so a held level raises one request.
REQ-014 SHALL implement the FSM IDLE -> GRANT -> ALARM -> COOLDOWN -> IDLE, with state encoding internal.
REQ-015 SHALL, in IDLE with pend != 0, move to GRANT on the next edge; with pend == 0, stay in IDLE.
REQ-016 SHALL, in GRANT, select the first set pend bit searching upward from rr_ptr with wrap-around, load alarm_ch, clear that pend bit, load timer = ALARM_CYCLES-1, and enter ALARM.
REQ-017 SHALL assert alarm exactly while in ALARM, for ALARM_CYCLES cycles when ack is not asserted.
REQ-018 SHALL, in ALARM, go to COOLDOWN when the timer reaches 0 or ack=1, whichever comes first, and load timer = COOLDOWN_CYCLES-1.
REQ-019 SHALL, in COOLDOWN, count down with alarm=0, then enter IDLE at timer 0.
REQ-020 SHALL set rr_ptr = alarm_ch+1, modulo NUM_CH, on GRANT->ALARM, giving round-robin fairness.
REQ-021 SHALL give set priority when a pend bit is cleared in GRANT and a new rising edge arrives on the same channel in the same cycle; the bit stays 1.
REQ-022 SHALL continue latching rising edges into pend in every state; ack outside ALARM SHALL have no effect on the FSM.
REQ-023 SHALL hold alarm_ch stable from GRANT until the next GRANT.
REQ-024 SHALL use 16-bit timers that never wrap below 0.

Reset
REQ-025 SHALL, with rst_n=0 at a clk edge, force: state IDLE, alarm=0, alarm_ch=0, pend=0, escalate=0, rr_ptr=0, timer=0, warn_in history=0, escalation count=0.
REQ-026 SHALL abort any alarm or cooldown on reset mid-operation, with alarm low on the first edge where rst_n is sampled low.
REQ-027 SHALL not treat a warn_in already high when reset is released as an edge until the first cycle after release: the history register loads warn_in during the first cycle out of reset.

Configuration
REQ-028 SHALL compile escalation logic under macro WARN_ESCALATE_EN: a 4-bit count increments on each ALARM end by timeout and clears on ack in ALARM; escalate=1 when count >= ESC_THRESH, cleared on that ack.
REQ-029 SHALL, without WARN_ESCALATE_EN, tie escalate to constant 0 and include no count register.

Verification
REQ-030 SHALL cover: single request, NUM_CH=4, ALARM_CYCLES=10, COOLDOWN_CYCLES=5, warn_in=4'b0100 -> GRANT next cycle, alarm high 10 cycles with alarm_ch=2, then 5 low cycles, pend=0.
REQ-031 SHALL cover: warn_in=4'b1011 rising together -> alarms serviced in order ch0, ch1, ch3, each separated by cooldown.
REQ-032 SHALL cover: ack pulsed on the 3rd alarm cycle -> alarm drops next edge, COOLDOWN starts, alarm lasts 3 cycles.
REQ-033 SHALL cover: ch1 held high throughout -> exactly one alarm; ch1 dropped and raised during ALARM -> second request pending and served after cooldown.
REQ-034 SHALL cover: rst_n low for 1 cycle mid-ALARM -> all outputs 0 the next cycle, and a pending request does not survive.
REQ-035 SHALL cover, with WARN_ESCALATE_EN, ESC_THRESH=3: three timed-out alarms -> escalate=1 after the third ALARM exit; ack during the fourth alarm -> escalate=0.
